// File: rtl/mult_sched_pkg.sv
// Shared constants and helpers for the shared-multiplier scheduler.
package mult_sched_pkg;

    localparam int W      = 123;
    localparam int PROD_W = 2 * W;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_karatsuba.sv
// Combinational W x W unsigned multiplier, one level of Karatsuba decomposition.
module mult_karatsuba #(
    parameter int W = 123
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    localparam int H  = W / 2;
    localparam int HW = W - H;
    localparam int SW = HW + 1;
    localparam int PW = 2 * W;

    logic [H-1:0]      a_lo, b_lo;
    logic [HW-1:0]     a_hi, b_hi;
    logic [SW-1:0]     a_sum, b_sum;
    logic [2*H-1:0]    z0;
    logic [2*HW-1:0]   z2;
    logic [2*SW-1:0]   z1_full;
    logic [PW-1:0]     mid;

    assign a_lo    = a[H-1:0];
    assign b_lo    = b[H-1:0];
    assign a_hi    = a[W-1:H];
    assign b_hi    = b[W-1:H];
    assign a_sum   = SW'(a_lo) + SW'(a_hi);
    assign b_sum   = SW'(b_lo) + SW'(b_hi);
    assign z0      = (2*H)'(a_lo) * (2*H)'(b_lo);
    assign z2      = (2*HW)'(a_hi) * (2*HW)'(b_hi);
    assign z1_full = (2*SW)'(a_sum) * (2*SW)'(b_sum);

    // Cross term al*bh + ah*bl is never negative, so the subtraction cannot wrap.
    assign mid = PW'(z1_full) - PW'(z2) - PW'(z0);
    assign p   = (PW'(z2) << (2*H)) + (mid << H) + PW'(z0);

endmodule

// File: rtl/mult_rr_arb.sv
// Round-robin grant among N_REQ requesters; pointer moves past each winner.
module mult_rr_arb
    import mult_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id
);
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
        grant_valid = en && found;
        grant       = '0;
        rr_ptr_d    = rr_ptr_q;
        if (grant_valid) begin
            grant[grant_id] = 1'b1;
            rr_ptr_d        = ID_W'((int'(grant_id) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Two-stage scheduler sharing one multiplier: operand register S1, product register S2.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = mult_sched_pkg::W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*W-1:0]           req_a,
    input  logic [N_REQ*W-1:0]           req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [id_width(N_REQ)-1:0]   rsp_id,
    output logic [2*W-1:0]               rsp_data,
    output logic                         busy
);
    localparam int ID_W = id_width(N_REQ);
    localparam int PW   = 2 * W;

    logic            s1_valid_q, s1_valid_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [W-1:0]    s1_b_q, s1_b_d;
    logic            s2_valid_q, s2_valid_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic [PW-1:0]   s2_prod_q, s2_prod_d;

    logic            s1_adv, s2_adv, arb_en;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic [PW-1:0]   mult_p;

    assign s2_adv = !s2_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    // Holding grants off during reset keeps req_ready low before the first edge clears state.
    assign arb_en = s1_adv && rst_n;

    mult_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (arb_en),
        .req_valid   (req_valid),
        .grant       (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    mult_karatsuba #(
        .W (W)
    ) u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mult_p)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_prod_d  = s2_prod_q;
        if (s1_adv) begin
            s1_valid_d = grant_valid;
            if (grant_valid) begin
                s1_id_d = grant_id;
                s1_a_d  = req_a[int'(grant_id)*W +: W];
                s1_b_d  = req_b[int'(grant_id)*W +: W];
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_id_d    = s1_id_q;
            s2_prod_d  = mult_p;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Payload registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        s1_id_q   <= s1_id_d;
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s2_id_q   <= s2_id_d;
        s2_prod_q <= s2_prod_d;
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_prod_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters sharing the multiplier.
REQ-002 The block SHALL have parameter W, default 123, the operand width; the product width is 2*W (246).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: per-requester operand-pair valid.
REQ-006 The block SHALL have port req_ready, output, N_REQ bits: per-requester grant/accept; it is one-hot or zero.
REQ-007 The block SHALL have port req_a, input, N_REQ*W bits: packed operand A per requester, requester i at bits [i*W +: W].
REQ-008 The block SHALL have port req_b, input, N_REQ*W bits: packed operand B, same packing as req_a.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: the result register holds a product.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port rsp_id, output, clog2(N_REQ) bits: index of the requester that owns rsp_data.
REQ-012 The block SHALL have port rsp_data, output, 2*W bits: the unsigned product A*B.
REQ-013 The block SHALL have port busy, output, 1 bit: high while either pipeline stage holds a valid entry.

Function
REQ-014 The block SHALL share one instance of the existing combinational W x W Karatsuba multiplier between the requesters. The multiplier sits between an operand register (S1) and a result register (S2).
REQ-015 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-016 A response transfer SHALL occur when rsp_valid and rsp_ready are both high in the same cycle.
REQ-017 Stall and advance rules SHALL be:
- s2_adv = !s2_valid || rsp_ready
- s1_adv = !s1_valid || s2_adv
REQ-018 Grant SHALL be round-robin:
- when s1_adv is high, req_ready[g] is asserted for the first requester g with req_valid high, searching from pointer rr_ptr upward and wrapping modulo N_REQ;
- req_ready is 0 otherwise.
REQ-019 req_ready SHALL depend combinationally on req_valid, rr_ptr, s1_valid, s2_valid and rsp_ready only; it SHALL NOT depend on operand data.
REQ-020 On a grant to g, rr_ptr SHALL become (g+1) mod N_REQ. With no grant, rr_ptr SHALL hold.
REQ-021 On a grant, S1 SHALL capture {valid=1, id=g, a, b}. If s1_adv is high and there is no grant, s1_valid SHALL clear.
REQ-022 When s2_adv is high, S2 SHALL capture {valid=s1_valid, id=s1_id, product=mult(s1_a, s1_b)}. The product is exactly 2*W bits with no truncation.
REQ-023 Latency SHALL be 2 cycles: an operand pair accepted in cycle T produces rsp_valid in cycle T+2 when rsp_ready has been high throughout.
REQ-024 Sustained throughput SHALL be one product per cycle.
REQ-025 While rsp_valid is high and rsp_ready is low, rsp_data and rsp_id SHALL be held stable. S1 SHALL hold if it is full, and at most one further request SHALL be accepted, into an empty S1.
REQ-026 Responses SHALL be returned in acceptance order.
REQ-027 A requester SHALL NOT withdraw or alter operands while its valid is high and it is not granted; the block SHALL NOT check this.
REQ-028 A requester that deasserts valid while ungranted SHALL lose its turn without changing rr_ptr.
REQ-029 When a response leaves and a new request enters in the same cycle, both transfers SHALL complete.
REQ-030 busy SHALL equal s1_valid | s2_valid.

Reset
REQ-031 When rst_n is low at a rising clock edge, the block SHALL clear s1_valid, s2_valid and rr_ptr to 0.
REQ-032 While rst_n is low, req_ready SHALL be 0, and rsp_valid and busy SHALL read 0 from the first clock edge with rst_n low.
REQ-033 Operand and product registers SHALL NOT require reset; rsp_data is don't-care while rsp_valid is 0.
REQ-034 An in-flight operation SHALL be discarded by a reset applied mid-operation, and no response SHALL be issued for it.

Structure
REQ-035 A shared package SHALL hold the constants W and PROD_W=2*W, and the requester-id width function.
REQ-036 One sub-module SHALL exist: mult_rr_arb, the N_REQ round-robin grant logic with pointer update. The multiplier SHALL be instantiated unmodified.

Verification
REQ-037 Scenario, single request: req0 with A=3, B=5, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_id=0, rsp_data=15.
REQ-038 Scenario, maximum operands: A=B=2^123-1 -> rsp_data = 2^246 - 2^124 + 1.
REQ-039 Scenario, fairness: all 4 requesters valid continuously, rsp_ready=1 -> grants follow 0,1,2,3,0,1,...; one response per cycle; ids in the same order.
REQ-040 Scenario, backpressure: rsp_ready=0 for 5 cycles with 4 requesters valid -> exactly 2 accepts; rsp_data held stable; after release the remaining requests drain in order without loss or duplication.
REQ-041 Scenario, mid-operation reset: rst_n low for 1 cycle with S1 and S2 full -> next cycle rsp_valid=0, busy=0, rr_ptr=0, and the first grant after reset goes to the lowest-index valid requester.
REQ-042 Scenario, random regression: 10k random operand pairs with random valid and ready -> every product matches the reference A*B, and every accepted request gets exactly one response in order.
